// File: rtl/memory_burst_reader.sv
// memory_burst_reader
//
// Port-B burst reader for a 32-bit true dual-port memory. A start pulse in
// IDLE issues BEATS consecutive reads from BASE_ADDR upward. The memory
// returns each word one cycle after its read. The returned words are packed
// into one wide word, with beat 0 in the low bits, and offered through a
// valid/ready handshake.
//
// Handshake: out_data is offered while out_valid=1. It transfers on any rising
// edge where out_valid && out_ready. out_valid never drops before that
// transfer, and out_data does not change while out_valid is high.
//
// Optional feature: define MEMORY_BURST_READER_SUM_EN to add out_sum. It is the
// sum modulo 2^16 of bits [15:0] of every captured beat in the current burst.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   start        burst request, only honoured in IDLE
//   busy         high whenever the FSM is not in IDLE
//   mem_en_b     port-B read enable
//   mem_we_b     port-B write enable (always 0)
//   mem_addr_b   port-B address
//   mem_rdata_b  port-B read data, one cycle after mem_en_b
//   out_data     assembled burst; beat i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid    out_data offered to the consumer
//   out_ready    consumer accepts
//   dbg_state    current FSM state (0 IDLE, 1 ISSUE, 2 DRAIN, 3 HOLD)
//   out_sum      low-half checksum of the burst (MEMORY_BURST_READER_SUM_EN only)
module memory_burst_reader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int BEATS      = 4,
    parameter int BASE_ADDR  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        mem_en_b,
    output logic                        mem_we_b,
    output logic [ADDR_WIDTH-1:0]       mem_addr_b,
    input  logic [DATA_WIDTH-1:0]       mem_rdata_b,
    output logic [BEATS*DATA_WIDTH-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [1:0]                  dbg_state
`ifdef MEMORY_BURST_READER_SUM_EN
    ,
    output logic [15:0]                 out_sum
`endif
);

    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_next_state;
    logic [CNT_W-1:0]            r_issue_cnt;
    logic [CNT_W-1:0]            r_cap_cnt;
    // Tracks the memory's one-cycle read latency: high when mem_rdata_b is valid.
    logic                        r_cap_vld;
    logic [BEATS*DATA_WIDTH-1:0] r_out_data;
    logic                        w_start_burst;
`ifdef MEMORY_BURST_READER_SUM_EN
    logic [15:0]                 r_sum;
`endif

    assign w_start_burst = (r_state == S_IDLE) && start;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        mem_en_b     = 1'b0;
        mem_addr_b   = '0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_en_b   = 1'b1;
                // Address arithmetic wraps naturally at 2^ADDR_WIDTH.
                mem_addr_b = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(r_issue_cnt);
                if (r_issue_cnt == LAST_BEAT) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_cap_vld && (r_cap_cnt == LAST_BEAT)) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_issue_cnt <= '0;
            r_cap_cnt   <= '0;
            r_cap_vld   <= 1'b0;
            r_out_data  <= '0;
`ifdef MEMORY_BURST_READER_SUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_cap_vld <= mem_en_b;
            if (w_start_burst) begin
                r_issue_cnt <= '0;
                r_cap_cnt   <= '0;
`ifdef MEMORY_BURST_READER_SUM_EN
                r_sum       <= '0;
`endif
            end else begin
                if (mem_en_b) begin
                    r_issue_cnt <= r_issue_cnt + 1'b1;
                end
                // Captures run one cycle behind issues and overlap ISSUE.
                if (r_cap_vld) begin
                    for (int i = 0; i < BEATS; i++) begin
                        if (r_cap_cnt == CNT_W'(i)) begin
                            r_out_data[i*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata_b;
                        end
                    end
                    r_cap_cnt <= r_cap_cnt + 1'b1;
`ifdef MEMORY_BURST_READER_SUM_EN
                    r_sum     <= r_sum + mem_rdata_b[15:0];
`endif
                end
            end
        end
    end

    assign mem_we_b  = 1'b0;
    assign out_data  = r_out_data;
    assign dbg_state = r_state;
`ifdef MEMORY_BURST_READER_SUM_EN
    assign out_sum   = r_sum;
`endif

endmodule

// File: tb/tb_memory_burst_reader.sv
// Testbench for memory_burst_reader. It uses a default instance and a second
// instance with BASE_ADDR=0xFFFE to exercise address wrap. Both share one
// behavioural memory with a registered port-B read.
module tb_memory_burst_reader;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         out_ready = 1'b1;
    logic         busy, mem_en_b, mem_we_b, out_valid;
    logic [15:0]  mem_addr_b;
    logic [31:0]  mem_rdata_b;
    logic [127:0] out_data;
    logic [1:0]   dbg_state;

    logic         start_w = 1'b0;
    logic         out_ready_w = 1'b1;
    logic         busy_w, mem_en_b_w, mem_we_b_w, out_valid_w;
    logic [15:0]  mem_addr_b_w;
    logic [31:0]  mem_rdata_b_w;
    logic [127:0] out_data_w;
    logic [1:0]   dbg_state_w;
`ifdef MEMORY_BURST_READER_SUM_EN
    logic [15:0]  out_sum, out_sum_w;
    logic [15:0]  exp_sum_q[$];
`endif

    logic [31:0]  mem [0:65535];

    logic [127:0] exp_q[$];
    logic [15:0]  exp_addr_q[$];

    int total = 0;
    int bad = 0;
    int hs_cnt = 0;

    // Clock and memory model.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en_b)   mem_rdata_b   <= mem[mem_addr_b];
        if (mem_en_b_w) mem_rdata_b_w <= mem[mem_addr_b_w];
    end

    memory_burst_reader dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .mem_en_b(mem_en_b), .mem_we_b(mem_we_b), .mem_addr_b(mem_addr_b),
        .mem_rdata_b(mem_rdata_b), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .dbg_state(dbg_state)
`ifdef MEMORY_BURST_READER_SUM_EN
        , .out_sum(out_sum)
`endif
    );

    memory_burst_reader #(.BASE_ADDR(16'hFFFE)) dut_w (
        .clk(clk), .reset(reset), .start(start_w), .busy(busy_w),
        .mem_en_b(mem_en_b_w), .mem_we_b(mem_we_b_w), .mem_addr_b(mem_addr_b_w),
        .mem_rdata_b(mem_rdata_b_w), .out_data(out_data_w), .out_valid(out_valid_w),
        .out_ready(out_ready_w), .dbg_state(dbg_state_w)
`ifdef MEMORY_BURST_READER_SUM_EN
        , .out_sum(out_sum_w)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Loads words at addresses 1..4 and queues the expected results of one burst.
    task automatic load_and_expect(input logic [31:0] d0, input logic [31:0] d1,
                                   input logic [31:0] d2, input logic [31:0] d3,
                                   input logic [15:0] esum);
        mem[1] = d0; mem[2] = d1; mem[3] = d2; mem[4] = d3;
        exp_q.push_back({d3, d2, d1, d0});
        for (int a = 1; a <= 4; a++) exp_addr_q.push_back(16'(a));
`ifdef MEMORY_BURST_READER_SUM_EN
        exp_sum_q.push_back(esum);
`else
        if (esum == 16'hFFFF) begin end
`endif
    endtask

    // Scoreboard: pops expected read addresses on each issued read and the
    // expected word on each handshake. Samples 2 time units after the falling
    // edge, after the directed sequence has driven its inputs.
    always @(negedge clk) begin
        #2;
        chk("we_b", {127'd0, mem_we_b}, 128'd0);
        if (mem_en_b) begin
            chk("read_pending", {127'd0, exp_addr_q.size() > 0}, 128'd1);
            if (exp_addr_q.size() > 0) chk("read_addr", {112'd0, mem_addr_b}, {112'd0, exp_addr_q.pop_front()});
        end
        if (out_valid && out_ready) begin
            hs_cnt++;
            chk("hs_pending", {127'd0, exp_q.size() > 0}, 128'd1);
            if (exp_q.size() > 0) chk("out_data_hs", out_data, exp_q.pop_front());
`ifdef MEMORY_BURST_READER_SUM_EN
            if (exp_sum_q.size() > 0) chk("out_sum_hs", {112'd0, out_sum}, {112'd0, exp_sum_q.pop_front()});
`endif
        end
    end

    initial begin
        logic [127:0] word1;
        logic [31:0]  rd [4];
        logic [15:0]  rsum;
        int           en_cnt;
        int           hs_before;
        logic [15:0]  wrap_addr [4];
        logic [127:0] wrap_word;

        word1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_en", {127'd0, mem_en_b}, 128'd0);
        chk("rst_addr", {112'd0, mem_addr_b}, 128'd0);
        chk("rst_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_data", out_data, 128'd0);
        chk("rst_state", {126'd0, dbg_state}, 128'd0);
`ifdef MEMORY_BURST_READER_SUM_EN
        chk("rst_sum", {112'd0, out_sum}, 128'd0);
`endif
        reset = 1'b0;

        // Burst 1: out_ready held high; cycle 0 is this falling edge.
        @(negedge clk);
        load_and_expect(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 16'hAAAA);
        start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("b1_en_c%0d", c), {127'd0, mem_en_b}, {127'd0, (c >= 1 && c <= 4)});
            chk($sformatf("b1_valid_c%0d", c), {127'd0, out_valid}, {127'd0, c == 6});
            chk($sformatf("b1_busy_c%0d", c), {127'd0, busy}, {127'd0, c <= 6});
            if (c == 6) begin
                chk("b1_data", out_data, word1);
`ifdef MEMORY_BURST_READER_SUM_EN
                chk("b1_sum", {112'd0, out_sum}, {112'd0, 16'hAAAA});
`endif
            end
        end

        // Burst 2, back to back: out_ready low for 10 valid cycles.
        load_and_expect(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 16'hAAAA);
        start = 1'b1;
        out_ready = 1'b0;
        hs_before = hs_cnt;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c >= 6 && c <= 15) begin
                chk($sformatf("b2_valid_c%0d", c), {127'd0, out_valid}, 128'd1);
                chk($sformatf("b2_data_c%0d", c), out_data, word1);
            end
            if (c == 15) out_ready = 1'b1;
            if (c == 16) begin
                chk("b2_busy_after", {127'd0, busy}, 128'd0);
                chk("b2_valid_after", {127'd0, out_valid}, 128'd0);
                chk("b2_data_retained", out_data, word1);
            end
        end
        chk("b2_hs_count", 128'(hs_cnt - hs_before), 128'd1);

        // Burst 3: extra start pulses in cycles 2, 4 and 6 are ignored.
        load_and_expect(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 16'hAAAA);
        start = 1'b1;
        en_cnt = 0;
        hs_before = hs_cnt;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (mem_en_b) en_cnt++;
            start = (c == 2 || c == 4 || c == 6);
        end
        chk("b3_en_cycles", 128'(en_cnt), 128'd4);
        chk("b3_hs_count", 128'(hs_cnt - hs_before), 128'd1);
        chk("b3_idle", {126'd0, dbg_state}, 128'd0);

        // Burst 4: reset in cycle 3 aborts; a fresh burst then completes.
        mem[1] = 32'hDEAD0001; mem[2] = 32'hDEAD0002; mem[3] = 32'hDEAD0003; mem[4] = 32'hDEAD0004;
        for (int a = 1; a <= 4; a++) exp_addr_q.push_back(16'(a));
        start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 3) reset = 1'b1;
        end
        chk("rst_mid_state", {126'd0, dbg_state}, 128'd0);
        chk("rst_mid_en", {127'd0, mem_en_b}, 128'd0);
        chk("rst_mid_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_mid_busy", {127'd0, busy}, 128'd0);
        chk("rst_mid_data", out_data, 128'd0);
        exp_addr_q.delete();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) rd[i] = $urandom();
        rsum = rd[0][15:0] + rd[1][15:0] + rd[2][15:0] + rd[3][15:0];
        load_and_expect(rd[0], rd[1], rd[2], rd[3], rsum);
        start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 6) chk("b4_data", out_data, {rd[3], rd[2], rd[1], rd[0]});
        end
        chk("b4_idle", {127'd0, busy}, 128'd0);

        // Wrap instance: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
        wrap_addr[0] = 16'hFFFE; wrap_addr[1] = 16'hFFFF;
        wrap_addr[2] = 16'h0000; wrap_addr[3] = 16'h0001;
        for (int i = 0; i < 4; i++) mem[wrap_addr[i]] = $urandom();
        wrap_word = {mem[16'h0001], mem[16'h0000], mem[16'hFFFF], mem[16'hFFFE]};
        start_w = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start_w = 1'b0;
            chk($sformatf("wr_en_c%0d", c), {127'd0, mem_en_b_w}, {127'd0, (c >= 1 && c <= 4)});
            if (c <= 4) chk($sformatf("wr_addr_c%0d", c), {112'd0, mem_addr_b_w}, {112'd0, wrap_addr[c-1]});
            if (c == 6) begin
                chk("wr_valid", {127'd0, out_valid_w}, 128'd1);
                chk("wr_data", out_data_w, wrap_word);
            end
        end
        chk("wr_busy_after", {127'd0, busy_w}, 128'd0);

        @(negedge clk);
        #3;
        chk("exp_q_empty", 128'(exp_q.size()), 128'd0);
        chk("addr_q_empty", 128'(exp_addr_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
